// File: rtl/mvm_stream_pkg.sv
// Shared types and sizes for the MVM input stream transmitter.
// Provides matrix dimension, word width, FSM state and word type.
package mvm_stream_pkg;
    localparam int MVM_K = 3;
    localparam int MVM_W = 14;

    typedef enum logic [1:0] {
        IDLE,
        SEND_MAT,
        SEND_VEC
    } tx_state_t;

    typedef logic signed [MVM_W-1:0] mvm_word_t;
endpackage

// File: rtl/mvm_stream_tx.sv
// Serializes one MVM job (K*K matrix + K vector) onto a valid/ready
// word stream; a reused matrix is skipped and only the vector is sent.
// Ports: clk, reset (sync, active-high);
//   job_valid/job_ready/job_new_matrix/job_matrix/job_vector : job side
//   out_valid/out_ready/out_data/out_new_matrix/out_last   : stream side
module mvm_stream_tx
    import mvm_stream_pkg::*;
#(
    parameter int K = MVM_K,
    parameter int W = MVM_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic                job_new_matrix,
    input  logic [K*K*W-1:0]    job_matrix,
    input  logic [K*W-1:0]      job_vector,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic                out_new_matrix,
    output logic                out_last
);
    localparam int NM = K * K;
    localparam int CW = (NM > 1) ? $clog2(NM) : 1;
    localparam logic [CW-1:0] MAT_LAST = CW'(NM - 1);
    localparam logic [CW-1:0] VEC_LAST = CW'(K - 1);

    tx_state_t          r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_loaded;
    logic [NM*W-1:0]    r_mat;
    logic [K*W-1:0]     r_vec;
    logic               r_valid;
    logic signed [W-1:0] r_data;
    logic               r_nm;
    logic               r_last;

    logic               w_accept;
    logic               w_fire;
    logic               w_eff_new;
    logic [CW-1:0]      w_cnt_nx;

    assign job_ready      = (r_state == IDLE);
    assign w_accept       = job_valid && job_ready;
    assign w_fire         = r_valid && out_ready;
    // The first job after reset has no matrix downstream yet.
    assign w_eff_new      = job_new_matrix || !r_loaded;
    assign w_cnt_nx       = r_cnt + CW'(1);

    assign out_valid      = r_valid;
    assign out_data       = r_data;
    assign out_new_matrix = r_nm;
    assign out_last       = r_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_loaded <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_nm     <= 1'b0;
            r_last   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mat   <= job_matrix;
                        r_vec   <= job_vector;
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        // Word 0 comes straight from the job fields since
                        // the shadow regs load on this same edge.
                        if (w_eff_new) begin
                            r_state <= SEND_MAT;
                            r_data  <= job_matrix[0 +: W];
                            r_nm    <= 1'b1;
                            r_last  <= 1'b0;
                        end else begin
                            r_state <= SEND_VEC;
                            r_data  <= job_vector[0 +: W];
                            r_nm    <= 1'b0;
                            r_last  <= (K == 1);
                        end
                    end
                end
                SEND_MAT: begin
                    if (w_fire) begin
                        r_nm <= 1'b0;
                        if (r_cnt == MAT_LAST) begin
                            r_state  <= SEND_VEC;
                            r_cnt    <= '0;
                            r_loaded <= 1'b1;
                            r_data   <= r_vec[0 +: W];
                            r_last   <= (K == 1);
                        end else begin
                            r_cnt  <= w_cnt_nx;
                            r_data <= r_mat[w_cnt_nx*W +: W];
                            r_last <= 1'b0;
                        end
                    end
                end
                SEND_VEC: begin
                    if (w_fire) begin
                        if (r_cnt == VEC_LAST) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_valid <= 1'b0;
                            r_data  <= '0;
                            r_last  <= 1'b0;
                        end else begin
                            r_cnt  <= w_cnt_nx;
                            r_data <= r_vec[w_cnt_nx*W +: W];
                            r_last <= (w_cnt_nx == VEC_LAST);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mvm_stream_tx.sv
// Self-checking bench for mvm_stream_tx: directed job table, reset
// corner cases and a randomized stall run against a word-queue model.
module tb_mvm_stream_tx;
    import mvm_stream_pkg::*;

    localparam int K  = 3;
    localparam int W  = 14;
    localparam int NM = K * K;

    logic            clk = 1'b0;
    logic            reset;
    logic            job_valid;
    logic            job_ready;
    logic            job_new_matrix;
    logic [NM*W-1:0] job_matrix;
    logic [K*W-1:0]  job_vector;
    logic            out_valid;
    logic            out_ready;
    mvm_word_t       out_data;
    logic            out_new_matrix;
    logic            out_last;

    mvm_stream_tx #(.K(K), .W(W)) dut (
        .clk            (clk),
        .reset          (reset),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_new_matrix (job_new_matrix),
        .job_matrix     (job_matrix),
        .job_vector     (job_vector),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_new_matrix (out_new_matrix),
        .out_last       (out_last)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic      nm;
        mvm_word_t mat [NM];
        mvm_word_t vec [K];
        int        n;
        mvm_word_t w [NM+K];
        logic      first_nm;
    } vec_t;

    vec_t tbl [4];

    typedef struct {
        mvm_word_t data;
        logic      nm;
        logic      last;
    } exp_t;

    exp_t exp_q [$];
    logic mon_en  = 1'b0;
    logic rnd_run = 1'b0;

    task automatic scramble();
        for (int e = 0; e < NM; e++) job_matrix[e*W +: W] = 14'($urandom);
        for (int e = 0; e < K; e++) job_vector[e*W +: W] = 14'($urandom);
        job_new_matrix = 1'($urandom);
    endtask

    task automatic wait_ready(input string name, input int budget);
        int g = 0;
        while (!job_ready && g < budget) begin
            step();
            g++;
        end
        chk(name, 32'(job_ready), 32'd1);
    endtask

    task automatic run_entry(input int idx);
        wait_ready($sformatf("t%0d_ready_wait", idx), 100);
        for (int e = 0; e < NM; e++) job_matrix[e*W +: W] = tbl[idx].mat[e];
        for (int e = 0; e < K; e++) job_vector[e*W +: W] = tbl[idx].vec[e];
        job_new_matrix = tbl[idx].nm;
        job_valid = 1'b1;
        out_ready = 1'b1;
        step();
        job_valid = 1'b0;
        scramble();
        for (int i = 0; i < tbl[idx].n; i++) begin
            chk($sformatf("t%0d_w%0d_valid", idx, i), 32'(out_valid), 32'd1);
            chk($sformatf("t%0d_w%0d_data", idx, i),
                32'(out_data), 32'(tbl[idx].w[i]));
            chk($sformatf("t%0d_w%0d_nm", idx, i), 32'(out_new_matrix),
                32'(i == 0 && tbl[idx].first_nm));
            chk($sformatf("t%0d_w%0d_last", idx, i), 32'(out_last),
                32'(i == tbl[idx].n - 1));
            step();
        end
        chk($sformatf("t%0d_done_valid", idx), 32'(out_valid), 32'd0);
        chk($sformatf("t%0d_done_ready", idx), 32'(job_ready), 32'd1);
    endtask

    // Stream monitor for the randomized run: hold rule and word order.
    initial begin
        logic        p_stall;
        logic [16:0] p_bundle;
        exp_t        e;
        p_stall = 1'b0;
        p_bundle = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                p_stall = 1'b0;
            end else begin
                if (p_stall)
                    chk("hold", 32'({out_valid, out_data, out_new_matrix,
                        out_last}), 32'(p_bundle));
                if (!out_valid)
                    chk("idle_flags", 32'({out_new_matrix, out_last}), 32'd0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rand_word", 32'({out_data, out_new_matrix,
                            out_last}), 32'({e.data, e.nm, e.last}));
                    end
                end
                p_stall = out_valid && !out_ready;
                p_bundle = {out_valid, out_data, out_new_matrix, out_last};
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table: entry 0 is the first job after reset with
        // new=0 and must still carry its matrix.
        for (int i = 0; i < 4; i++) begin
            for (int e = 0; e < NM; e++) tbl[i].mat[e] = 14'(e + 1);
            for (int e = 0; e < K; e++) tbl[i].vec[e] = 14'(e + 10);
            for (int e = 0; e < NM + K; e++) tbl[i].w[e] = 14'(e + 1);
            tbl[i].n = 12;
            tbl[i].nm = 1'b1;
            tbl[i].first_nm = 1'b1;
        end
        tbl[0].nm = 1'b0;
        tbl[1].nm = 1'b0;
        tbl[1].n = 3;
        tbl[1].first_nm = 1'b0;
        for (int e = 0; e < NM; e++) tbl[1].mat[e] = 14'(100 + e);
        tbl[1].vec[0] = 14'sh0007;
        tbl[1].vec[1] = 14'sh3FF9;
        tbl[1].vec[2] = 14'sh0000;
        tbl[1].w[0] = 14'sh0007;
        tbl[1].w[1] = 14'sh3FF9;
        tbl[1].w[2] = 14'sh0000;
        tbl[3].nm = 1'b0;
        tbl[3].n = 3;
        tbl[3].first_nm = 1'b0;
        tbl[3].vec[0] = 14'sh3FFF;
        tbl[3].vec[1] = 14'sh2000;
        tbl[3].vec[2] = 14'sh1FFF;
        tbl[3].w[0] = 14'sh3FFF;
        tbl[3].w[1] = 14'sh2000;
        tbl[3].w[2] = 14'sh1FFF;

        reset = 1'b1;
        job_valid = 1'b0;
        out_ready = 1'b0;
        job_new_matrix = 1'b0;
        job_matrix = '0;
        job_vector = '0;
        repeat (2) step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_nm", 32'(out_new_matrix), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_job_ready", 32'(job_ready), 32'd1);
        reset = 1'b0;
        step();

        for (int i = 0; i < 4; i++) run_entry(i);

        // Reset while word 5 of a matrix job is stalled.
        wait_ready("t6_ready_wait", 100);
        for (int e = 0; e < NM; e++) job_matrix[e*W +: W] = tbl[2].mat[e];
        for (int e = 0; e < K; e++) job_vector[e*W +: W] = tbl[2].vec[e];
        job_new_matrix = 1'b1;
        job_valid = 1'b1;
        out_ready = 1'b1;
        step();
        job_valid = 1'b0;
        repeat (4) step();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("t6_stall%0d_valid", s), 32'(out_valid), 32'd1);
            chk($sformatf("t6_stall%0d_data", s), 32'(out_data), 32'd5);
            step();
        end
        reset = 1'b1;
        job_valid = 1'b1;
        step();
        reset = 1'b0;
        job_valid = 1'b0;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_job_ready", 32'(job_ready), 32'd1);
        chk("t6_rst_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        step();
        chk("t6_no_more_words", 32'(out_valid), 32'd0);
        run_entry(0);

        // Randomized jobs with 50% back-pressure against a word-queue model.
        begin
            logic loaded;
            logic nm;
            int   jobs;
            int   g;
            loaded = 1'b1;
            mon_en = 1'b1;
            rnd_run = 1'b1;
            fork
                while (rnd_run) begin
                    @(posedge clk);
                    #1;
                    if (rnd_run) out_ready = 1'($urandom_range(0, 1));
                end
            join_none
            jobs = 0;
            for (int j = 0; j < 1500; j++) begin
                g = 0;
                while (!job_ready && g < 2000) begin
                    step();
                    g++;
                end
                if (!job_ready) begin
                    chk("rand_ready_wait", 32'(job_ready), 32'd1);
                    break;
                end
                scramble();
                nm = job_new_matrix;
                if (nm || !loaded) begin
                    for (int e = 0; e < NM; e++)
                        exp_q.push_back('{job_matrix[e*W +: W], e == 0, 1'b0});
                    loaded = 1'b1;
                end
                for (int e = 0; e < K; e++)
                    exp_q.push_back('{job_vector[e*W +: W], 1'b0, e == K-1});
                job_valid = 1'b1;
                step();
                job_valid = 1'b0;
                scramble();
                jobs++;
            end
            chk("rand_jobs", 32'(jobs), 32'd1500);
            g = 0;
            while (exp_q.size() != 0 && g < 5000) begin
                step();
                g++;
            end
            chk("rand_drain", 32'(exp_q.size()), 32'd0);
            repeat (3) step();
            rnd_run = 1'b0;
            mon_en = 1'b0;
            out_ready = 1'b1;
            step();
            chk("rand_end_valid", 32'(out_valid), 32'd0);
            chk("rand_end_ready", 32'(job_ready), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
